// File: rtl/wb_port_arb.sv
// Purpose : 4:1 round-robin arbiter for the register-file write-back port, with
//           per-requester burst lock (up to MAX_BURST beats) and drives the mux select.
// Latency : request sampled at edge N -> grant/select/write-enable valid in cycle N+1.
// Backpr. : w_hold_1 blocks new beats (fresh grants and burst continuations); a beat
//           already registered always completes its cycle.
// Ports   : w_clk, w_rst_n (async, active-low)
//           w_req_4  [3:0] in   level requests (0=ALU, 1=MEM, 2=MULDIV, 3=CP0)
//           w_lock_4 [3:0] in   burst lock, qualified by the matching request bit
//           w_hold_1       in   register-file port frozen
//           w_gnt_4  [3:0] out  one-hot registered grant, one bit per write beat
//           w_sel_2  [1:0] out  write-back mux select, holds last value when idle
//           w_we_1         out  write enable, equals |w_gnt_4
//           w_busy_1       out  arbiter is in GRANT or BURST
module wb_port_arb #(
  parameter int WIDTH     = 32,  // width of the data path steered by w_sel_2
  parameter int MAX_BURST = 4    // max consecutive beats for a locked winner, 1..15
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic [3:0] w_req_4,
  input  logic [3:0] w_lock_4,
  input  logic       w_hold_1,
  output logic [3:0] w_gnt_4,
  output logic [1:0] w_sel_2,
  output logic       w_we_1,
  output logic       w_busy_1
);

  if (MAX_BURST < 1 || MAX_BURST > 15 || WIDTH < 1) begin : g_bad_param
    $error("wb_port_arb: MAX_BURST must be 1..15 and WIDTH >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [3:0] MAX_BEATS = 4'(MAX_BURST);

  state_t     state_q, state_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] sel_q,   sel_d;
  logic       we_q,    we_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [3:0] beat_q,  beat_d;

  logic [3:0] cand;
  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] rr_idx;
  logic       burst_ok;

  // Round-robin pick. The grant being served this cycle is masked so an
  // unlocked requester cannot take two beats back to back. Scanning from the
  // farthest offset down lets the nearest candidate to ptr overwrite the rest.
  always_comb begin
    cand    = w_req_4 & ~gnt_q;
    win_vld = 1'b0;
    win_idx = ptr_q;
    rr_idx  = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      rr_idx = ptr_q + 2'(i);
      if (cand[rr_idx]) begin
        win_vld = 1'b1;
        win_idx = rr_idx;
      end
    end
  end

  // Continue the current winner only while it still requests with lock,
  // the port is not frozen, and its beat budget is not exhausted.
  always_comb begin
    burst_ok = (state_q != ST_IDLE) && w_req_4[sel_q] && w_lock_4[sel_q] &&
               !w_hold_1 && (beat_q < MAX_BEATS);
  end

  always_comb begin
    state_d = ST_IDLE;
    gnt_d   = 4'b0000;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    if (burst_ok) begin
      state_d = ST_BURST;
      gnt_d   = gnt_q;
      beat_d  = beat_q + 4'd1;
    end else begin
      // The current beat is the winner's last: rotate priority past it.
      if (state_q != ST_IDLE) begin
        ptr_d = sel_q + 2'd1;
      end
      if (!w_hold_1 && win_vld) begin
        state_d = ST_GRANT;
        gnt_d   = 4'b0001 << win_idx;
        sel_d   = win_idx;
        beat_d  = 4'd1;
      end
    end
    we_d = |gnt_d;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      we_q    <= 1'b0;
      ptr_q   <= 2'b00;
      beat_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  assign w_gnt_4  = gnt_q;
  assign w_sel_2  = sel_q;
  assign w_we_1   = we_q;
  assign w_busy_1 = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_port_arb.sv
// Scoreboard bench for wb_port_arb: the driver pushes the hand-computed output
// expected after each edge; an independent monitor pops and compares after
// every rising edge and also checks the one-hot / write-enable invariants.
module tb_wb_port_arb;

  logic       w_clk;
  logic       w_rst_n;
  logic [3:0] w_req_4;
  logic [3:0] w_lock_4;
  logic       w_hold_1;
  logic [3:0] w_gnt_4;
  logic [1:0] w_sel_2;
  logic       w_we_1;
  logic       w_busy_1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  wb_port_arb #(.WIDTH(32), .MAX_BURST(4)) dut (
    .w_clk    (w_clk),
    .w_rst_n  (w_rst_n),
    .w_req_4  (w_req_4),
    .w_lock_4 (w_lock_4),
    .w_hold_1 (w_hold_1),
    .w_gnt_4  (w_gnt_4),
    .w_sel_2  (w_sel_2),
    .w_we_1   (w_we_1),
    .w_busy_1 (w_busy_1)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every rising edge presents a new registered output.
  always begin
    exp_t e;
    @(posedge w_clk);
    #1;
    check("onehot", 32'($countones(w_gnt_4) <= 1), 32'd1);
    check("we_eq_or_gnt", 32'(w_we_1), 32'(|w_gnt_4));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt", 32'(w_gnt_4), 32'(e.gnt));
      check("sel", 32'(w_sel_2), 32'(e.sel));
      check("we", 32'(w_we_1), 32'(|e.gnt));
      check("busy", 32'(w_busy_1), 32'(e.busy));
    end
  end

  // Called at a falling edge: drive inputs, push the output expected after
  // the next rising edge, and return at the following falling edge.
  task automatic step(input logic [3:0] req, input logic [3:0] lock, input logic hold,
                      input logic [3:0] gnt, input logic [1:0] sel, input logic busy);
    exp_t e;
    w_req_4  = req;
    w_lock_4 = lock;
    w_hold_1 = hold;
    e.gnt  = gnt;
    e.sel  = sel;
    e.busy = busy;
    exp_q.push_back(e);
    @(posedge w_clk);
    @(negedge w_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(w_gnt_4), 32'd0);
    check({tag, "_sel"}, 32'(w_sel_2), 32'd0);
    check({tag, "_we"}, 32'(w_we_1), 32'd0);
    check({tag, "_busy"}, 32'(w_busy_1), 32'd0);
  endtask

  // Called at a falling edge; leaves reset released at a falling edge.
  task automatic do_reset();
    w_req_4  = 4'b0000;
    w_lock_4 = 4'b0000;
    w_hold_1 = 1'b0;
    w_rst_n  = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge w_clk);
    w_rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    w_rst_n  = 1'b0;
    w_req_4  = 4'b0000;
    w_lock_4 = 4'b0000;
    w_hold_1 = 1'b0;
    @(negedge w_clk);
    do_reset();

    // Single unlocked requester alternates grant / idle.
    step(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1);
    step(4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    step(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // ptr was left at 1; reset must return it to 0 so ALU wins first.
    do_reset();
    step(4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1);
    step(4'b1111, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1);
    step(4'b1111, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1);
    step(4'b1111, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1);
    step(4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // Move ptr to 2, check select holds while idle, then a full 4-beat burst.
    do_reset();
    step(4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);
    step(4'b0101, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
    step(4'b0101, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
    step(4'b0101, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
    step(4'b0101, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
    step(4'b0101, 4'b0100, 1'b0, 4'b0001, 2'd0, 1'b1);
    // ptr=3 after the burst: CP0 wins over MEM/MULDIV.
    step(4'b1111, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);

    // Lock on a requester that is not requesting is ignored.
    step(4'b0010, 4'b0100, 1'b0, 4'b0010, 2'd1, 1'b1);
    step(4'b0000, 4'b0100, 1'b0, 4'b0000, 2'd1, 1'b0);

    // Hold blocks a fresh grant; a grant already in flight survives hold.
    do_reset();
    step(4'b0010, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b0010, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1);
    w_hold_1 = 1'b1;
    #1;
    check("hold_mid_grant_gnt", 32'(w_gnt_4), 32'h2);
    check("hold_mid_grant_we", 32'(w_we_1), 32'd1);
    step(4'b0010, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0);
    step(4'b0010, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0);
    step(4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);

    // Hold cuts a burst short; afterwards the requester is granted afresh.
    step(4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1);
    step(4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1);
    step(4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0);
    step(4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // Reset during beat 2 of a MULDIV burst aborts it immediately.
    step(4'b0100, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
    step(4'b0100, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
    w_rst_n = 1'b0;
    #1;
    check_reset_outputs("midburst_rst");
    @(negedge w_clk);
    check_reset_outputs("held_rst");
    w_rst_n = 1'b1;
    step(4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);

    @(negedge w_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arb.md
WB_PORT_ARB -- requirements
Module: wb_port_arb

Interface
REQ-001 Parameter WIDTH, default 32: width of the write-back data path whose 4:1 mux select this block drives (documentation only; no data passes through this block).
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive grant cycles for one locked requester; legal range 1..15.
REQ-003 w_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 w_rst_n  in  1  asynchronous, active-low reset.
REQ-005 w_req_4  in  4  per-requester write-port request; bit0=ALU, bit1=MEM, bit2=MULDIV, bit3=CP0; level, held until granted.
REQ-006 w_lock_4  in  4  per-requester burst lock; meaningful only with the matching w_req_4 bit.
REQ-007 w_hold_1  in  1  register-file port frozen; blocks new grants.
REQ-008 w_gnt_4  out  4  one-hot grant, registered; one bit per beat.
REQ-009 w_sel_2  out  2  register-file write-back mux select = index of granted requester, registered.
REQ-010 w_we_1  out  1  register-file write enable, registered; high exactly when w_gnt_4 is non-zero.
REQ-011 w_busy_1  out  1  high when state is not IDLE.

Function
REQ-012 States: IDLE (no grant), GRANT (first beat to winner), BURST (further beats to same winner).
REQ-013 Arbitration at each rising edge: candidates = w_req_4 with the currently granted bit masked off; winner = first candidate in round-robin order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 Grant latency: request sampled at edge N with w_hold_1=0 -> w_gnt_4/w_sel_2/w_we_1 valid during cycle N+1 (one cycle).
REQ-015 Each grant cycle is one write beat; a requester receiving a grant shall count it consumed at that edge.
REQ-016 IDLE -> GRANT when w_hold_1=0 and any candidate; else stay IDLE with w_gnt_4=0, w_we_1=0.
REQ-017 GRANT/BURST -> BURST (same winner) when winner's w_req_4 and w_lock_4 bits are high, w_hold_1=0, and beats issued < MAX_BURST.
REQ-018 Otherwise GRANT/BURST -> GRANT with a new winner if w_hold_1=0 and a candidate exists, else -> IDLE.
REQ-019 Round-robin pointer ptr (2 bits) updates to (last winner + 1) mod 4 at the edge ending that winner's final beat; unchanged otherwise.
REQ-020 Beat counter reloads to 1 on entering GRANT, increments per BURST beat, saturates at MAX_BURST; MAX_BURST=1 disables bursts.
REQ-021 Unlocked requester holding w_req_4 continuously with no competitors receives grants on alternate cycles (masked during its own grant cycle).
REQ-022 w_hold_1 blocks only new beats (GRANT entry or BURST continuation); a beat already registered completes its cycle regardless of w_hold_1.
REQ-023 w_sel_2 retains its last value when no grant is active.
REQ-024 w_lock_4 without matching w_req_4 bit shall be ignored; lock changes mid-burst take effect at next edge.
REQ-025 w_gnt_4 shall never have more than one bit set; w_we_1 shall equal |w_gnt_4 every cycle.

Reset
REQ-026 While w_rst_n=0, asynchronously: state=IDLE, w_gnt_4=0000, w_sel_2=00, w_we_1=0, w_busy_1=0, ptr=0, beat counter=0.
REQ-027 Reset asserted mid-GRANT or mid-BURST shall abort the beat immediately; no grant in the first cycle after deassertion; arbitration resumes at the first rising edge with w_rst_n=1.

Verification
REQ-028 Reset, w_req_4=0001 held -> w_gnt_4 0001/w_sel_2 00/w_we_1 1 in cycle 1, 0000 cycle 2, 0001 cycle 3 (alternating).
REQ-029 ptr=0, w_req_4=1111 held, lock=0 -> grants 0001,0010,0100,1000,0001 on consecutive cycles, w_sel_2 00,01,10,11,00.
REQ-030 ptr=2, w_req_4=0101, w_lock_4=0100, MAX_BURST=4 -> 0100 for exactly 4 cycles, w_sel_2=10, then 0001; ptr=3 after burst.
REQ-031 w_hold_1=1 with w_req_4=0010 -> no grant; release -> 0010 one cycle later; hold rising during that grant cycle leaves it intact, blocks next.
REQ-032 w_rst_n pulled low during beat 2 of a burst -> all outputs 0 same cycle, ptr=0; after release w_req_4=1000 -> grant 1000 one cycle after first active edge.
